// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
// Module      : mem_stage
// Description : Pipeline memory stage. Drives a req/gnt/rvalid data-memory
//               port, aligns and formats load and store data, and passes
//               non-memory results straight through to writeback.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid_in,
    input  logic [31:0] alu_result_in,
    input  logic [31:0] store_data_in,
    input  logic [4:0]  rd_idx_in,
    input  logic        reg_we_in,
    input  logic        mem_read_in,
    input  logic        mem_write_in,
    input  logic [2:0]  funct3_in,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_gnt,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata,
    output logic [31:0] writeback_val_out,
    output logic [4:0]  rd_idx_out,
    output logic        reg_we_out,
    output logic        stall_out,
    output logic        err_out
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] sdata_q, sdata_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [4:0]  rd_q, rd_d;
    logic        reg_we_q, reg_we_d;
    logic        is_load_q, is_load_d;
    logic [31:0] load_q, load_d;

    logic        w_mem_op;
    logic        w_illegal;
    logic        w_launch;

    function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] a);
        case (size)
            2'b00:   byte_en = 4'b0001 << a;
            2'b01:   byte_en = a[1] ? 4'b1100 : 4'b0011;
            default: byte_en = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] replicate(input logic [1:0] size, input logic [31:0] sd);
        case (size)
            2'b00:   replicate = {4{sd[7:0]}};
            2'b01:   replicate = {2{sd[15:0]}};
            default: replicate = sd;
        endcase
    endfunction

    function automatic logic [31:0] format_load(input logic [2:0] f3, input logic [1:0] a,
                                                input logic [31:0] rd);
        logic [7:0]  b;
        logic [15:0] h;
        case (a)
            2'd0:    b = rd[7:0];
            2'd1:    b = rd[15:8];
            2'd2:    b = rd[23:16];
            default: b = rd[31:24];
        endcase
        h = a[1] ? rd[31:16] : rd[15:0];
        case (f3)
            3'b000:  format_load = {{24{b[7]}}, b};
            3'b100:  format_load = {24'd0, b};
            3'b001:  format_load = {{16{h[15]}}, h};
            3'b101:  format_load = {16'd0, h};
            default: format_load = rd;
        endcase
    endfunction

    always_comb begin
        w_mem_op  = ex_valid_in & (mem_read_in | mem_write_in);
        w_illegal = mem_read_in & mem_write_in;
        case (funct3_in)
            3'b000, 3'b100: ;
            3'b001, 3'b101: w_illegal = w_illegal | alu_result_in[0];
            3'b010:         w_illegal = w_illegal | (|alu_result_in[1:0]);
            default:        w_illegal = 1'b1;
        endcase
        w_launch = (state_q == S_IDLE) & w_mem_op & ~w_illegal;
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        sdata_d   = sdata_q;
        funct3_d  = funct3_q;
        rd_d      = rd_q;
        reg_we_d  = reg_we_q;
        is_load_d = is_load_q;
        load_d    = load_q;

        dmem_req          = 1'b0;
        dmem_we           = 1'b0;
        dmem_be           = 4'b0000;
        writeback_val_out = 32'd0;
        rd_idx_out        = rd_q;
        reg_we_out        = 1'b0;
        stall_out         = 1'b0;
        err_out           = 1'b0;

        case (state_q)
            S_IDLE: begin
                writeback_val_out = alu_result_in;
                rd_idx_out        = rd_idx_in;
                reg_we_out        = ex_valid_in & reg_we_in & ~w_mem_op;
                stall_out         = w_launch;
                err_out           = w_mem_op & w_illegal;
                if (w_launch) begin
                    addr_d    = alu_result_in;
                    sdata_d   = store_data_in;
                    funct3_d  = funct3_in;
                    rd_d      = rd_idx_in;
                    reg_we_d  = reg_we_in;
                    is_load_d = mem_read_in;
                    state_d   = S_REQ;
                end
            end
            S_REQ: begin
                dmem_req  = 1'b1;
                dmem_we   = ~is_load_q;
                dmem_be   = byte_en(funct3_q[1:0], addr_q[1:0]);
                stall_out = 1'b1;
                // A same-cycle rvalid is deliberately ignored; data comes in WAIT
                if (dmem_gnt) begin
                    state_d = is_load_q ? S_WAIT : S_DONE;
                end
            end
            S_WAIT: begin
                stall_out = 1'b1;
                if (dmem_rvalid) begin
                    load_d  = format_load(funct3_q, addr_q[1:0], dmem_rdata);
                    state_d = S_DONE;
                end
            end
            default: begin
                writeback_val_out = is_load_q ? load_q : 32'd0;
                reg_we_out        = is_load_q & reg_we_q & (|rd_q);
                state_d           = S_IDLE;
            end
        endcase
    end

    assign dmem_addr  = {addr_q[31:2], 2'b00};
    assign dmem_wdata = replicate(funct3_q[1:0], sdata_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            addr_q    <= 32'd0;
            sdata_q   <= 32'd0;
            funct3_q  <= 3'd0;
            rd_q      <= 5'd0;
            reg_we_q  <= 1'b0;
            is_load_q <= 1'b0;
            load_q    <= 32'd0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            sdata_q   <= sdata_d;
            funct3_q  <= funct3_d;
            rd_q      <= rd_d;
            reg_we_q  <= reg_we_d;
            is_load_q <= is_load_d;
            load_q    <= load_d;
        end
    end

endmodule
`default_nettype wire

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk and rst.
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 rst  in  1  synchronous active-high reset, sampled on the rising clk edge.
REQ-004 ex_valid_in  in  1  EX/MEM slot holds a valid instruction.
REQ-005 alu_result_in  in  32  ALU result; the effective address for loads and stores.
REQ-006 store_data_in, rd_idx_in, reg_we_in  in  32/5/1  store data, destination index, register write enable.
REQ-007 mem_read_in, mem_write_in  in  1/1  load op, store op.
REQ-008 funct3_in  in  3  access size: 000 byte, 001 half, 010 word, 100 byte unsigned, 101 half unsigned.
REQ-009 dmem_req, dmem_we  out  1/1  memory request, write strobe.
REQ-010 dmem_addr  out  32  word-aligned address, {addr[31:2],2'b00}.
REQ-011 dmem_wdata, dmem_be  out  32/4  lane-replicated store data, byte enables.
REQ-012 dmem_gnt, dmem_rvalid, dmem_rdata  in  1/1/32  request accepted, read data valid, read data.
REQ-013 writeback_val_out, rd_idx_out, reg_we_out  out  32/5/1  fields for the MEM/WB register.
REQ-014 stall_out  out  1  tells upstream to hold the EX/MEM slot.
REQ-015 err_out  out  1  one-cycle pulse for a misaligned or illegal access.

Function
REQ-016 The FSM SHALL have four states, with transitions as follows.
- IDLE: SHALL go to REQ on a valid, legal memory op; otherwise SHALL stay in IDLE.
- REQ: SHALL go to WAIT on dmem_gnt for a load; SHALL go to DONE on dmem_gnt for a store.
- WAIT: SHALL go to DONE on dmem_rvalid.
- DONE: SHALL go to IDLE unconditionally.
REQ-017 Non-memory op in IDLE: zero latency, combinational pass-through.
- writeback_val_out = alu_result_in.
- rd_idx_out = rd_idx_in.
- reg_we_out = ex_valid_in & reg_we_in.
- stall_out = 0.
REQ-018 Launching a legal memory op in IDLE SHALL:
- capture address, store data, funct3, rd_idx, reg_we and the op type into internal registers;
- assert stall_out and force reg_we_out = 0 in that same cycle.
REQ-019 In REQ and WAIT, stall_out SHALL be 1 and reg_we_out SHALL be 0.
REQ-020 In REQ, dmem_req SHALL be 1, with dmem_addr, dmem_we, dmem_be and dmem_wdata held stable from the captured registers until dmem_gnt is sampled high.
- dmem_req SHALL be 0 in every other state.
REQ-021 In WAIT, on dmem_rvalid the formatted load data SHALL be registered.
- dmem_rvalid in IDLE, REQ or DONE SHALL be ignored.
REQ-022 In DONE, for exactly one cycle:
- stall_out = 0;
- rd_idx_out = captured rd_idx;
- reg_we_out = captured reg_we for a load, 0 for a store;
- writeback_val_out = registered load data for a load, 0 for a store.
- Input fields SHALL be ignored, so the held instruction is not relaunched.
REQ-023 A minimum load SHALL take 4 cycles, IDLE->REQ->WAIT->DONE, with gnt and rvalid each arriving in the first cycle of their state. A minimum store SHALL take 3 cycles.
REQ-024 Byte enables SHALL be formed as follows.
- byte: 4'b0001 << addr[1:0];
- half: 4'b0011 when addr[1]=0, 4'b1100 when addr[1]=1;
- word: 4'b1111.
- Loads SHALL drive the same dmem_be pattern as stores.
REQ-025 Store data SHALL be lane-replicated.
- byte: {4{sd[7:0]}};
- half: {2{sd[15:0]}};
- word: sd.
REQ-026 Load data SHALL be the lane selected by addr[1:0].
- Byte and half loads (000/001) SHALL sign-extend to 32 bits; unsigned loads (100/101) SHALL zero-extend; a word load SHALL pass through.
REQ-027 The following are illegal accesses:
- half with addr[0]=1;
- word with addr[1:0]!=0;
- funct3 of 011, 110 or 111;
- mem_read_in and mem_write_in both high.
REQ-028 An illegal access in IDLE SHALL:
- pulse err_out = 1 for one cycle;
- issue no dmem_req;
- drive reg_we_out = 0 and stall_out = 0;
- leave the FSM in IDLE.
REQ-029 A legal memory op with rd_idx_in=0 SHALL still perform the access but SHALL drive reg_we_out = 0 in DONE.
REQ-030 dmem_gnt and dmem_rvalid arriving in the same REQ cycle for a load SHALL be treated as gnt only.
- The FSM SHALL go to WAIT and wait for a later rvalid.
- Memory SHALL NOT assert rvalid in the gnt cycle.

Reset
REQ-031 On a rising clk edge with rst=1, the FSM SHALL go to IDLE and all internal capture and data registers SHALL clear to 0.
REQ-032 While the state is IDLE after reset, outputs SHALL be: dmem_req 0, stall_out 0, err_out 0, reg_we_out 0 (with ex_valid_in=0), dmem_be 0, dmem_we 0.
REQ-033 Reset mid-operation (in REQ or WAIT) SHALL abandon the access.
- dmem_req SHALL drop in the cycle after the reset edge.
- A late dmem_rvalid SHALL be ignored.
- No register write SHALL be issued.
REQ-034 Reset SHALL have priority over all FSM transitions in the same cycle.

Verification
REQ-035 ALU op: ex_valid=1, alu=0x0000_1234, rd=5, we=1 -> same cycle wb=0x1234, rd=5, we=1, stall=0.
REQ-036 lb: addr=0x103, rdata=0x80FF_0000, gnt in cycle 1, rvalid in cycle 2. The bench SHALL check:
- dmem_addr=0x100 and be=4'b1000;
- stall high in cycles 0-2;
- in cycle 3, wb=0xFFFF_FF80 and we=1.
REQ-037 sh: addr=0x202, sd=0x0000_ABCD -> be=4'b1100, wdata=0xABCD_ABCD, we=1. Gnt delayed 3 cycles SHALL hold req and address stable. DONE cycle SHALL have reg_we_out=0.
REQ-038 lw at addr=0x101 -> err_out=1 for one cycle, dmem_req never asserted, reg_we_out=0.
REQ-039 lw issued, rst=1 while in WAIT, then rvalid=1 next cycle -> state IDLE, no reg_we_out pulse, dmem_req=0.
REQ-040 lhu at addr=0x006, rdata=0x8001_0000, rd=0 -> wb=0x0000_8001 in DONE, reg_we_out=0.
